ahb_byte_stream_monitor: RTL and testbench
==========================================

AHB_BYTE_STREAM_MONITOR -- requirements
Module: ahb_byte_stream_monitor

Interface
REQ-001 Parameter AW, default 32, HADDR and out_addr width.
REQ-002 Parameter DW, default 64, HWDATA/HRDATA width; legal values 8, 16, 32, 64, 128, 256, 512, 1024.
REQ-003 Parameter DEPTH, default 4, beat FIFO entries; power of two, at least 2.
REQ-004 Parameter LOG_READS, default 0; when 1, completed read beats are also streamed.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 HREADY  in  1  bus transfer-complete strobe.
REQ-008 HADDR  in  AW  address-phase address.
REQ-009 HWRITE  in  1  address-phase direction; 1 means write.
REQ-010 HSIZE  in  3  address-phase size code.
REQ-011 HTRANS  in  2  address-phase transfer type, decoded with state_t.
REQ-012 HWDATA  in  DW  write data.
REQ-013 HRDATA  in  DW  read data.
REQ-014 out_valid  out  1  byte available.
REQ-015 out_ready  in  1  consumer accepts the byte.
REQ-016 out_addr  out  AW  byte address.
REQ-017 out_byte  out  8  byte value.
REQ-018 out_write  out  1  direction of the source beat.
REQ-019 out_last  out  1  last byte of a beat.
REQ-020 overflow  out  1  sticky; set when a beat is dropped.
REQ-021 size_err  out  1  sticky; set when 2**HSIZE exceeds DW/8.
REQ-022 drop_cnt  out  16  count of dropped beats; saturates at 16'hFFFF.
REQ-023 byte_cnt  out  32  count of bytes handed off; wraps modulo 2**32.

Function
- REQ-024 Address-phase capture: on a cycle with HREADY=1 and HTRANS NONSEQ or SEQ, the block SHALL latch HADDR, HSIZE and HWRITE as the pending data phase.
  - Writes are always captured.
  - Reads are captured only when LOG_READS=1.
- REQ-025 Data-phase completion: the pending data phase SHALL complete on the first later cycle with HREADY=1, whatever HTRANS is in that cycle, BUSY and IDLE included.
  - On completion, the block latches HWDATA for writes or HRDATA for reads.
  - It pushes one beat {addr, size, data, write} into the beat FIFO.
- REQ-026 With HREADY=0 the pending phase SHALL hold. A capture and a completion in the same cycle SHALL both take effect: back-to-back pipelining.
- REQ-027 Beat contents:
  - Lane range is lo = addr mod DW/8, n = 2**size.
  - If n > DW/8, the block SHALL use n = DW/8 and set size_err.
  - If lo+n > DW/8, the block SHALL clamp the range at the top lane.
- REQ-028 Serializer states: IDLE and EMIT.
  - IDLE->EMIT when the FIFO is non-empty. The serializer pops the head and sets lane k = lo.
  - In EMIT: out_valid=1, out_byte = data[8k+:8], out_addr = addr + (k - lo), out_write = the beat direction.
  - out_last=1 when k = lo+n-1.
- REQ-029 Handshake:
  - A byte is transferred when out_valid && out_ready; byte_cnt then increments.
  - The outputs SHALL hold stable while out_valid && !out_ready.
  - A transfer with out_last=1 SHALL load the next head with no bubble if the FIFO is non-empty, else go to IDLE.
- REQ-030 Latency: a beat completed in cycle t SHALL present its first byte no earlier than t+2 and, with an empty FIFO and an idle serializer, exactly at t+2.
- REQ-031 FIFO full: when a completion occurs while the FIFO is full and no pop happens in the same cycle:
  - the beat SHALL be dropped;
  - overflow SHALL be set;
  - drop_cnt SHALL increment.
  - A push and a pop in the same cycle on a full FIFO SHALL be accepted.
- REQ-032 Pointers: read and write pointers SHALL be log2(DEPTH)+1 bits and wrap naturally; full and empty are derived from the MSB and index comparison.
- REQ-033 out_addr arithmetic SHALL be modulo 2**AW.

Reset
- REQ-034 With rst_n=0 at a clock edge, all state SHALL clear:
  - pending phase, FIFO (pointers emptied) and serializer go to IDLE;
  - out_valid=0, out_last=0, out_addr=0, out_byte=0, out_write=0;
  - overflow=0, size_err=0, drop_cnt=0, byte_cnt=0.
- REQ-035 Reset mid-beat SHALL abandon the beat being emitted and the pending data phase. Emission resumes only with beats completed after release.
- REQ-036 Reset SHALL have no asynchronous path; rst_n is sampled only at the clk edge.

Structure
- REQ-037 state_t and the AHB width constants SHALL stay in ahb_pkg. The serializer state enum and HSIZE-to-bytes function SHALL be added to ahb_pkg. The beat record SHALL be a local packed struct, because it depends on the parameters.
- REQ-038 The beat FIFO SHALL be a sub-module, ahb_beat_fifo, parameterised by width and DEPTH. It provides push/pop/full/empty and the same-cycle push-on-full-with-pop rule.

Verification
- REQ-039 DW=64. Write NONSEQ at 0x1003, HSIZE=0, HWDATA byte3=0xA5, out_ready=1 -> one byte: addr 0x1003, 0xA5, out_last=1, at completion+2.
- REQ-040 DW=64. 4-beat INCR word writes from 0x2000 with a BUSY cycle after beat 2 and one HREADY=0 wait state -> 16 bytes at 0x2000..0x200F in order, no duplicates.
- REQ-041 DEPTH=4. out_ready=0 and 6 single-beat writes -> 4 beats retained, overflow=1, drop_cnt=2. Then out_ready=1 -> exactly the first 4 beats emitted.
- REQ-042 LOG_READS=0 then 1. Read of 0x3000, HSIZE=1 -> no output when 0; when 1, bytes 0x3000 and 0x3001 with out_write=0.
- REQ-043 DW=32. HSIZE=3 write -> size_err=1, 4 bytes emitted.
- REQ-044 Reset mid-beat with out_ready toggling. Assert rst_n=0 for one cycle during byte 2 of 4 -> all outputs zero next cycle; the next beat emits cleanly.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB definitions for the byte stream monitor.
//
// Contents:
//   HTRANS_W, HSIZE_W : widths of the AHB HTRANS and HSIZE fields
//   state_t           : HTRANS transfer type decode
//   ser_state_t       : byte serializer states
//   hsize_bytes()     : HSIZE code to transfer size in bytes
//   last_lane()       : highest byte lane a beat touches, clamped to the bus
package ahb_pkg;

    localparam int HTRANS_W = 2;
    localparam int HSIZE_W  = 3;

    typedef enum logic [HTRANS_W-1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } state_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_t;

    function automatic int unsigned hsize_bytes(input logic [HSIZE_W-1:0] hsize);
        return 32'd1 << hsize;
    endfunction

    // A beat starts at lane lo and covers 2**hsize lanes. The size is first
    // limited to the bus width, then the range is cut at the top lane so an
    // unaligned beat never wraps into the low lanes.
    function automatic int unsigned last_lane(input int unsigned          lo,
                                              input logic [HSIZE_W-1:0]   hsize,
                                              input int unsigned          lanes);
        int unsigned n;
        int unsigned top;
        n = hsize_bytes(hsize);
        if (n > lanes) n = lanes;
        top = lo + n - 1;
        if (top > lanes - 1) top = lanes - 1;
        return top;
    endfunction

endpackage

// File: rtl/ahb_byte_stream_monitor_if.sv
// ahb_byte_stream_monitor_if -- AHB snoop signals plus the byte output stream.
//
// Signals:
//   HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HRDATA : observed AHB bus
//   out_valid, out_ready                                 : byte handshake
//   out_addr, out_byte, out_write, out_last              : byte payload
// Modports:
//   master : drives the bus signals and out_ready, receives the byte stream
//   slave  : the monitor; observes the bus, produces the byte stream
interface ahb_byte_stream_monitor_if
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) ();

    logic                HREADY;
    logic [AW-1:0]       HADDR;
    logic                HWRITE;
    logic [HSIZE_W-1:0]  HSIZE;
    logic [HTRANS_W-1:0] HTRANS;
    logic [DW-1:0]       HWDATA;
    logic [DW-1:0]       HRDATA;

    logic                out_valid;
    logic                out_ready;
    logic [AW-1:0]       out_addr;
    logic [7:0]          out_byte;
    logic                out_write;
    logic                out_last;

    modport master (
        output HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HRDATA, out_ready,
        input  out_valid, out_addr, out_byte, out_write, out_last
    );

    modport slave (
        input  HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HRDATA, out_ready,
        output out_valid, out_addr, out_byte, out_write, out_last
    );

endinterface

// File: rtl/ahb_beat_fifo.sv
// ahb_beat_fifo -- synchronous FIFO holding captured AHB beats.
//
// Parameters: W (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data; refused when full unless popping
//   pop, dout  : read request and head entry (dout valid while !empty)
//   full, empty: status derived from the extended pointers
//   count      : number of stored entries
module ahb_beat_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // One extra pointer bit tells a full FIFO from an empty one when the
    // index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[IW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle:
    // the freed slot is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; emptying the pointers is enough
    // to make its contents invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/ahb_byte_stream_monitor.sv
// ahb_byte_stream_monitor -- snoops AHB data phases and replays each completed
// beat as a stream of single bytes with their byte addresses.
//
// Parameters:
//   AW        : address width
//   DW        : data bus width (8, 16, ... 1024)
//   DEPTH     : beat FIFO entries (power of two, >= 2)
//   LOG_READS : also stream completed read beats when 1
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : AHB snoop inputs and the byte stream (slave modport)
//   overflow   : sticky, a beat was dropped on a full FIFO
//   size_err   : sticky, a beat was wider than the bus
//   drop_cnt   : dropped beats, saturating
//   byte_cnt   : bytes handed off, wrapping
module ahb_byte_stream_monitor
    import ahb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int DEPTH     = 4,
    parameter bit LOG_READS = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ahb_byte_stream_monitor_if.slave   bus,
    output logic                       overflow,
    output logic                       size_err,
    output logic [15:0]                drop_cnt,
    output logic [31:0]                byte_cnt
);

    localparam int LANES = DW / 8;
    localparam int LW    = $clog2(LANES) + 1;
    localparam int PW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [HSIZE_W-1:0] size;
        logic [DW-1:0]      data;
        logic               write;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // ------------------------------------------------------------------
    // Address phase capture and data phase completion
    // ------------------------------------------------------------------
    state_t             htrans;
    logic               capture;
    logic               complete;
    logic               pend_vld;
    logic [AW-1:0]      pend_addr;
    logic [HSIZE_W-1:0] pend_size;
    logic               pend_write;
    beat_t              push_beat;

    assign htrans   = state_t'(bus.HTRANS);
    assign capture  = bus.HREADY
                   && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ)
                   && (bus.HWRITE || LOG_READS);
    // The pending phase completes on any ready cycle, whatever HTRANS says.
    assign complete = pend_vld && bus.HREADY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_size  <= '0;
            pend_write <= 1'b0;
        end else if (bus.HREADY) begin
            // Completion and the next capture share this edge, so a new
            // address phase simply replaces the one that just finished.
            pend_vld   <= capture;
            pend_addr  <= bus.HADDR;
            pend_size  <= bus.HSIZE;
            pend_write <= bus.HWRITE;
        end
    end

    assign push_beat = '{addr:  pend_addr,
                         size:  pend_size,
                         data:  pend_write ? bus.HWDATA : bus.HRDATA,
                         write: pend_write};

    // ------------------------------------------------------------------
    // Beat FIFO
    // ------------------------------------------------------------------
    logic [BEAT_W-1:0] head_bits;
    beat_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW-1:0]     fifo_count;
    logic              pop;
    logic              drop;

    ahb_beat_fifo #(
        .W     (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (complete),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head = head_bits;
    assign drop = complete && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Serializer
    // The beat being emitted stays at the FIFO head and its slot is freed
    // only with its last byte, so it still counts against DEPTH. Lanes are
    // tracked as an offset from the head's first lane, which lets the next
    // head start on the very cycle after a last-byte transfer.
    // ------------------------------------------------------------------
    ser_state_t state;
    ser_state_t state_nxt;
    logic [LW-1:0] off;
    logic [LW-1:0] off_nxt;
    logic [LW-1:0] head_lo;
    logic [LW-1:0] head_last;
    logic [LW-1:0] lane;
    logic          at_last;
    logic          xfer;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        head_lo   = LW'(head.addr & AW'(LANES - 1));
        head_last = LW'(last_lane(32'(head_lo), head.size, LANES));
    end

    assign lane    = head_lo + off;
    assign at_last = (lane == head_last);
    assign xfer    = (state == SER_EMIT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SER_IDLE;
            off   <= '0;
        end else begin
            state <= state_nxt;
            off   <= off_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        off_nxt   = off;
        pop       = 1'b0;
        unique case (state)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = SER_EMIT;
                    off_nxt   = '0;
                end
            end
            SER_EMIT: begin
                if (bus.out_ready) begin
                    if (at_last) begin
                        pop     = 1'b1;
                        off_nxt = '0;
                        // Another beat is already queued, or arrives now and
                        // is guaranteed a slot because this pop frees one.
                        if (!(fifo_count > PW'(1) || complete)) state_nxt = SER_IDLE;
                    end else begin
                        off_nxt = off + 1'b1;
                    end
                end
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    // Payload is forced to zero whenever no byte is offered.
    assign bus.out_valid = (state == SER_EMIT);
    assign bus.out_byte  = bus.out_valid ? head.data[{lane, 3'b000} +: 8] : 8'h00;
    assign bus.out_addr  = bus.out_valid ? head.addr + AW'(off) : '0;
    assign bus.out_write = bus.out_valid && head.write;
    assign bus.out_last  = bus.out_valid && at_last;

    // ------------------------------------------------------------------
    // Status and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            size_err <= 1'b0;
            drop_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            end
            if (complete && hsize_bytes(pend_size) > 32'(LANES)) size_err <= 1'b1;
            if (xfer) byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_byte_stream_monitor.sv
// tb_ahb_byte_stream_monitor -- directed bench for the AHB byte stream monitor.
// Three instances share one stimulus: A (DW=64), B (DW=64, reads logged) and
// C (DW=32). Bytes handed off by each instance are collected into queues.
module tb_ahb_byte_stream_monitor;
    import ahb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        hready;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [63:0] hwdata;
    logic [63:0] hrdata;
    logic        rdy;

    logic        ovf_a, serr_a, ovf_b, serr_b, ovf_c, serr_c;
    logic [15:0] drop_a, drop_b, drop_c;
    logic [31:0] bcnt_a, bcnt_b, bcnt_c;

    ahb_byte_stream_monitor_if #(.AW(32), .DW(64)) bus_a ();
    ahb_byte_stream_monitor_if #(.AW(32), .DW(64)) bus_b ();
    ahb_byte_stream_monitor_if #(.AW(32), .DW(32)) bus_c ();

    assign bus_a.HREADY = hready;  assign bus_b.HREADY = hready;  assign bus_c.HREADY = hready;
    assign bus_a.HADDR  = haddr;   assign bus_b.HADDR  = haddr;   assign bus_c.HADDR  = haddr;
    assign bus_a.HWRITE = hwrite;  assign bus_b.HWRITE = hwrite;  assign bus_c.HWRITE = hwrite;
    assign bus_a.HSIZE  = hsize;   assign bus_b.HSIZE  = hsize;   assign bus_c.HSIZE  = hsize;
    assign bus_a.HTRANS = htrans;  assign bus_b.HTRANS = htrans;  assign bus_c.HTRANS = htrans;
    assign bus_a.HWDATA = hwdata;  assign bus_b.HWDATA = hwdata;  assign bus_c.HWDATA = hwdata[31:0];
    assign bus_a.HRDATA = hrdata;  assign bus_b.HRDATA = hrdata;  assign bus_c.HRDATA = hrdata[31:0];
    assign bus_a.out_ready = rdy;  assign bus_b.out_ready = rdy;  assign bus_c.out_ready = rdy;

    ahb_byte_stream_monitor #(.AW(32), .DW(64), .DEPTH(4), .LOG_READS(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .overflow(ovf_a), .size_err(serr_a), .drop_cnt(drop_a), .byte_cnt(bcnt_a));
    ahb_byte_stream_monitor #(.AW(32), .DW(64), .DEPTH(4), .LOG_READS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .overflow(ovf_b), .size_err(serr_b), .drop_cnt(drop_b), .byte_cnt(bcnt_b));
    ahb_byte_stream_monitor #(.AW(32), .DW(32), .DEPTH(4), .LOG_READS(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c),
        .overflow(ovf_c), .size_err(serr_c), .drop_cnt(drop_c), .byte_cnt(bcnt_c));

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        last;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    rec_t q_c[$];

    // Outputs are stable between edges; a byte is taken at the next rising
    // edge when valid and ready are both high and reset is not asserted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.out_valid && bus_a.out_ready)
                q_a.push_back('{bus_a.out_addr, bus_a.out_byte, bus_a.out_write, bus_a.out_last});
            if (bus_b.out_valid && bus_b.out_ready)
                q_b.push_back('{bus_b.out_addr, bus_b.out_byte, bus_b.out_write, bus_b.out_last});
            if (bus_c.out_valid && bus_c.out_ready)
                q_c.push_back('{bus_c.out_addr, bus_c.out_byte, bus_c.out_write, bus_c.out_last});
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk_rec(input logic [31:0] a, input logic [7:0] d,
                                    input logic w, input logic l);
        return '{a, d, w, l};
    endfunction

    // Data word whose lanes for addresses a..a+n-1 carry the byte a[7:0]+0x10.
    function automatic logic [63:0] mk_data(input logic [31:0] a, input int n);
        logic [63:0] d;
        logic [31:0] x;
        d = '0;
        for (int i = 0; i < n; i++) begin
            x = a + 32'(i);
            d[8*x[2:0] +: 8] = x[7:0] + 8'h10;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hready = 1'b1;
        htrans = TRANS_IDLE;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_bus();
        tick();
        rst_n = 1'b1;
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    // NONSEQ address phase, then a ready data phase with IDLE on the bus.
    task automatic single_xfer(input logic w, input logic [31:0] a,
                               input logic [2:0] sz, input logic [63:0] d);
        hready = 1'b1;
        htrans = TRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        tick();
        htrans = TRANS_IDLE;
        hwdata = d;
        hrdata = d;
        tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        hready = 1'b1;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = '0;
        htrans = TRANS_IDLE;
        hwdata = '0;
        hrdata = '0;
        rdy    = 1'b1;
        tick();
        do_reset();

        // Reset state
        check("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_last",  64'(bus_a.out_last),  64'd0);
        check("rst_addr",  64'(bus_a.out_addr),  64'd0);
        check("rst_byte",  64'(bus_a.out_byte),  64'd0);
        check("rst_write", 64'(bus_a.out_write), 64'd0);
        check("rst_flags", 64'({ovf_a, serr_a}), 64'd0);
        check("rst_drop",  64'(drop_a), 64'd0);
        check("rst_bcnt",  64'(bcnt_a), 64'd0);

        // Single byte write, exact latency of two cycles after completion
        rdy = 1'b1;
        single_xfer(1'b1, 32'h1003, 3'd0, 64'h0000_0000_A500_0000);
        check("t1_valid_t1", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("t1_valid_t2", 64'(bus_a.out_valid), 64'd1);
        check("t1_addr",  64'(bus_a.out_addr),  64'h1003);
        check("t1_byte",  64'(bus_a.out_byte),  64'hA5);
        check("t1_last",  64'(bus_a.out_last),  64'd1);
        check("t1_write", 64'(bus_a.out_write), 64'd1);
        tick();
        check("t1_done", 64'(bus_a.out_valid), 64'd0);
        check("t1_bcnt", 64'(bcnt_a), 64'd1);

        // INCR4 word burst with a BUSY cycle and a wait state
        do_reset();
        hwrite = 1'b1;
        hsize  = 3'd2;
        hready = 1'b1; htrans = TRANS_NONSEQ; haddr = 32'h2000; tick();
        htrans = TRANS_SEQ;  haddr = 32'h2004; hwdata = mk_data(32'h2000, 4); tick();
        htrans = TRANS_BUSY; haddr = 32'h2008; hwdata = mk_data(32'h2004, 4); tick();
        htrans = TRANS_SEQ;  haddr = 32'h2008; hwdata = 64'hDEAD_BEEF_DEAD_BEEF; tick();
        hready = 1'b0; htrans = TRANS_SEQ; haddr = 32'h200C; hwdata = mk_data(32'h2008, 4); tick();
        hready = 1'b1; tick();
        htrans = TRANS_IDLE; hwdata = mk_data(32'h200C, 4); tick();
        run(40);
        check("t2_count", 64'(q_a.size()), 64'd16);
        for (int i = 0; i < 16 && i < q_a.size(); i++)
            check($sformatf("t2_byte%0d", i), 64'(q_a[i]),
                  64'(mk_rec(32'h2000 + 32'(i), 8'h10 + 8'(i), 1'b1, (i % 4) == 3)));
        check("t2_ovf",  64'(ovf_a), 64'd0);
        check("t2_bcnt", 64'(bcnt_a), 64'd16);

        // Six single-beat writes with the consumer stalled
        do_reset();
        rdy    = 1'b0;
        hwrite = 1'b1;
        hsize  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            htrans = TRANS_NONSEQ;
            haddr  = 32'h4000 + 32'(8 * i);
            hwdata = (i > 0) ? 64'(8'h60 + 8'(i - 1)) : 64'd0;
            tick();
        end
        htrans = TRANS_IDLE;
        hwdata = 64'h65;
        tick();
        run(4);
        check("t3_ovf",   64'(ovf_a),  64'd1);
        check("t3_drop",  64'(drop_a), 64'd2);
        check("t3_hold_addr", 64'(bus_a.out_addr), 64'h4000);
        check("t3_hold_byte", 64'(bus_a.out_byte), 64'h60);
        rdy = 1'b1;
        run(20);
        check("t3_count", 64'(q_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_a.size(); i++)
            check($sformatf("t3_beat%0d", i), 64'(q_a[i]),
                  64'(mk_rec(32'h4000 + 32'(8 * i), 8'h60 + 8'(i), 1'b1, 1'b1)));
        check("t3_idle", 64'(bus_a.out_valid), 64'd0);

        // Halfword read: ignored without read logging, streamed with it
        do_reset();
        single_xfer(1'b0, 32'h3000, 3'd1, 64'h0000_0000_0000_3CC3);
        run(10);
        check("t4_a_count", 64'(q_a.size()), 64'd0);
        check("t4_b_count", 64'(q_b.size()), 64'd2);
        if (q_b.size() >= 2) begin
            check("t4_b0", 64'(q_b[0]), 64'(mk_rec(32'h3000, 8'hC3, 1'b0, 1'b0)));
            check("t4_b1", 64'(q_b[1]), 64'(mk_rec(32'h3001, 8'h3C, 1'b0, 1'b1)));
        end

        // Doubleword write on the 32-bit instance exceeds the bus width
        do_reset();
        single_xfer(1'b1, 32'h5000, 3'd3, 64'h8877_6655_4433_2211);
        run(15);
        check("t5_serr_c",  64'(serr_c), 64'd1);
        check("t5_serr_a",  64'(serr_a), 64'd0);
        check("t5_c_count", 64'(q_c.size()), 64'd4);
        check("t5_a_count", 64'(q_a.size()), 64'd8);
        if (q_c.size() >= 4) begin
            check("t5_c0", 64'(q_c[0]), 64'(mk_rec(32'h5000, 8'h11, 1'b1, 1'b0)));
            check("t5_c3", 64'(q_c[3]), 64'(mk_rec(32'h5003, 8'h44, 1'b1, 1'b1)));
        end

        // Unaligned word at lane 6 is clamped at the top lane
        do_reset();
        single_xfer(1'b1, 32'h6006, 3'd2, 64'hB7B6_0000_0000_0000);
        run(10);
        check("t6_count", 64'(q_a.size()), 64'd2);
        if (q_a.size() >= 2) begin
            check("t6_b0", 64'(q_a[0]), 64'(mk_rec(32'h6006, 8'hB6, 1'b1, 1'b0)));
            check("t6_b1", 64'(q_a[1]), 64'(mk_rec(32'h6007, 8'hB7, 1'b1, 1'b1)));
        end
        check("t6_serr", 64'(serr_a), 64'd0);

        // Reset in the middle of a beat with the consumer toggling
        do_reset();
        rdy = 1'b0;
        single_xfer(1'b1, 32'h7000, 3'd2, 64'h0000_0000_7473_7271);
        for (int i = 0; i < 10 && !bus_a.out_valid; i++) tick();
        check("t7_started", 64'(bus_a.out_valid), 64'd1);
        rdy = 1'b1; tick();
        rdy = 1'b0; tick();
        check("t7_stall_addr", 64'(bus_a.out_addr), 64'h7001);
        rdy = 1'b1; tick();
        rdy = 1'b0;
        check("t7_pre_addr", 64'(bus_a.out_addr), 64'h7002);
        check("t7_pre_byte", 64'(bus_a.out_byte), 64'h73);
        rst_n = 1'b0;
        tick();
        check("t7_rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("t7_rst_out", 64'({bus_a.out_addr, bus_a.out_byte, bus_a.out_write, bus_a.out_last}), 64'd0);
        check("t7_rst_bcnt", 64'(bcnt_a), 64'd0);
        rst_n = 1'b1;
        q_a.delete();
        rdy = 1'b1;
        run(3);
        check("t7_quiet", 64'(bus_a.out_valid), 64'd0);
        single_xfer(1'b1, 32'h7100, 3'd0, 64'h9E);
        run(10);
        check("t7_count", 64'(q_a.size()), 64'd1);
        if (q_a.size() >= 1)
            check("t7_byte", 64'(q_a[0]), 64'(mk_rec(32'h7100, 8'h9E, 1'b1, 1'b1)));
        check("t7_bcnt", 64'(bcnt_a), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
